// File: rtl/cordic_element_ds.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cordic_element_ds
// Description : Digit-serial CORDIC micro-rotation stage (rotation/vectoring).
//               Optional half-up rounding of shifted terms: CORDIC_ROUND_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_element_ds #(
    parameter int DIG_W      = 2,
    parameter int NDIG       = 6,
    parameter int STG        = 1,
    parameter int ATAN       = 301,
    parameter int ONE_OVER_K = 1242
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Rdy,
    input  logic             Mode,
    input  logic             ISin,
    input  logic [DIG_W-1:0] Xin,
    input  logic [DIG_W-1:0] Yin,
    input  logic [DIG_W-1:0] Ain,
    output logic [DIG_W-1:0] Xout,
    output logic [DIG_W-1:0] Yout,
    output logic [DIG_W-1:0] Aout,
    output logic             ISout,
    output logic             Vld,
    output logic             Err
);

    localparam int c_W  = DIG_W * NDIG;
    localparam int c_CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [c_CW-1:0]       c_LAST = c_CW'(NDIG - 1);
    localparam logic signed [c_W-1:0] c_ATAN = c_W'(ATAN);
    localparam logic signed [c_W-1:0] c_K    = c_W'(ONE_OVER_K);
`ifdef CORDIC_ROUND_EN
    localparam int c_HSH = (STG > 0) ? STG - 1 : 0;
    localparam logic signed [c_W:0] c_HALF = (STG > 0) ? ((c_W+1)'(1) << c_HSH) : '0;
`endif

    // New digits enter at the top so digit 0 ends up in the LSD after NDIG shifts.
    function automatic logic [c_W-1:0] f_shin(input logic [c_W-1:0] cur,
                                              input logic [DIG_W-1:0] dig);
        return {dig, cur[c_W-1:DIG_W]};
    endfunction

    function automatic logic signed [c_W-1:0] f_shr(input logic signed [c_W-1:0] v);
`ifdef CORDIC_ROUND_EN
        logic signed [c_W:0] w_t;
        if (STG == 0) return v;
        w_t = ($signed({v[c_W-1], v}) + c_HALF) >>> STG;
        return w_t[c_W-1:0];
`else
        return v >>> STG;
`endif
    endfunction

    logic [c_W-1:0]  r_xi, r_yi, r_ai;
    logic            r_mode, r_is;
    logic [c_CW-1:0] r_icnt;
    logic            r_ibusy, r_wdone, r_err;

    logic [c_W-1:0]  r_xo, r_yo, r_ao;
    logic [c_CW-1:0] r_ocnt;
    logic            r_obusy, r_vld, r_isout;

    logic signed [c_W-1:0] w_x, w_y, w_a, w_xs, w_ys;
    logic signed [c_W-1:0] w_xn, w_yn, w_an;
    logic                  w_d;

    // Input deserialiser; a Rdy inside an open frame restarts it and flags Err.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_xi    <= '0;
            r_yi    <= '0;
            r_ai    <= '0;
            r_mode  <= 1'b0;
            r_is    <= 1'b0;
            r_icnt  <= '0;
            r_ibusy <= 1'b0;
            r_wdone <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_wdone <= 1'b0;
            if (Rdy) begin
                if (r_ibusy) r_err <= 1'b1;
                r_xi    <= f_shin(r_xi, Xin);
                r_yi    <= f_shin(r_yi, Yin);
                r_ai    <= f_shin(r_ai, Ain);
                r_mode  <= Mode;
                r_is    <= ISin;
                r_icnt  <= c_CW'(1);
                r_ibusy <= 1'b1;
            end else if (r_ibusy) begin
                r_xi   <= f_shin(r_xi, Xin);
                r_yi   <= f_shin(r_yi, Yin);
                r_ai   <= f_shin(r_ai, Ain);
                r_icnt <= r_icnt + c_CW'(1);
                if (r_icnt == c_LAST) begin
                    r_ibusy <= 1'b0;
                    r_wdone <= 1'b1;
                end
            end
        end
    end

    assign w_x  = $signed(r_xi);
    assign w_y  = $signed(r_yi);
    assign w_a  = $signed(r_ai);
    assign w_d  = r_mode ? w_y[c_W-1] : ~w_a[c_W-1];
    assign w_xs = f_shr(w_x);
    assign w_ys = f_shr(w_y);

    always_comb begin
        w_xn = w_d ? (w_x - w_ys)   : (w_x + w_ys);
        w_yn = w_d ? (w_y + w_xs)   : (w_y - w_xs);
        w_an = w_d ? (w_a - c_ATAN) : (w_a + c_ATAN);
        // The first rotation stage seeds the gain-compensated unit vector.
        if (STG == 0 && !r_mode) begin
            w_xn = c_K;
            w_yn = w_d ? c_K : -c_K;
        end
    end

    // Result register doubles as the output shifter; a load wins over the
    // final shift so back-to-back frames need no stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_xo    <= '0;
            r_yo    <= '0;
            r_ao    <= '0;
            r_ocnt  <= '0;
            r_obusy <= 1'b0;
            r_vld   <= 1'b0;
            r_isout <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            if (r_wdone) begin
                r_xo    <= w_xn;
                r_yo    <= w_yn;
                r_ao    <= w_an;
                r_ocnt  <= '0;
                r_obusy <= 1'b1;
                r_vld   <= 1'b1;
                r_isout <= r_is;
            end else if (r_obusy) begin
                r_xo   <= r_xo >> DIG_W;
                r_yo   <= r_yo >> DIG_W;
                r_ao   <= r_ao >> DIG_W;
                r_ocnt <= r_ocnt + c_CW'(1);
                if (r_ocnt == c_LAST) r_obusy <= 1'b0;
            end
        end
    end

    assign Xout  = r_obusy ? r_xo[DIG_W-1:0] : '0;
    assign Yout  = r_obusy ? r_yo[DIG_W-1:0] : '0;
    assign Aout  = r_obusy ? r_ao[DIG_W-1:0] : '0;
    assign ISout = r_isout;
    assign Vld   = r_vld;
    assign Err   = r_err;

endmodule
`default_nettype wire
